// File: rtl/sized_data_memory.sv
// sized_data_memory: single-port data memory with byte/half/word access,
// little-endian lanes, fault detection and a fixed accept-to-response latency.
//
// Ports:
//   clock, resetN            rising-edge clock, async active-low reset
//   req / ready              request handshake, accept on req && ready
//   address, writeData       byte address, right-aligned store data
//   memRead, memWrite        load / store select (both = fault, neither = no-op)
//   size, signExt            00 byte, 01 half, 10 word, 11 illegal; load extension
//   readData, fault          response payload, held until the next respValid
//   respValid                one-cycle response strobe, READ_LATENCY after accept
module sized_data_memory #(
  parameter int          ADDR_WIDTH   = 14,
  parameter logic [31:0] BASE_ADDR    = 32'h7FFF0000,
  parameter int          READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        req,
  output logic        ready,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [1:0]  size,
  input  logic        signExt,
  output logic [31:0] readData,
  output logic        respValid,
  output logic        fault
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  // Last BUSY count value before moving to RESP; BUSY is unused at latency 1.
  localparam logic [2:0] LAST = (READ_LATENCY > 1) ? 3'(READ_LATENCY - 2) : 3'd0;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic accept;

  // Contents start at zero and are never touched by reset.
  logic [31:0] mem [DEPTH] = '{default: '0};

  assign ready     = (state != BUSY);
  assign respValid = (state == RESP);
  assign accept    = req && ready;

  // ---------------- address decode / fault ----------------
  logic [31:0]           offset;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            lane;
  logic                  fault_c;

  assign offset   = address - BASE_ADDR;
  assign in_range = ({1'b0, offset} < (33'd1 << (ADDR_WIDTH + 2)));
  assign idx      = offset[ADDR_WIDTH+1:2];
  assign lane     = address[1:0];
  assign fault_c  = !in_range || (size == 2'b11) ||
                    ((size == 2'b01) && address[0]) ||
                    ((size == 2'b10) && (lane != 2'b00)) ||
                    (memRead && memWrite);

  // ---------------- load path ----------------
  logic [31:0] word, shifted, ext, result;

  assign word    = mem[idx];
  assign shifted = word >> {lane, 3'b000};

  always_comb begin
    ext = word;
    case (size)
      2'b00:   ext = {{24{signExt & shifted[7]}},  shifted[7:0]};
      2'b01:   ext = {{16{signExt & shifted[15]}}, shifted[15:0]};
      default: ext = word;
    endcase
  end

  assign result = (!fault_c && memRead) ? ext : 32'd0;

  // ---------------- store path ----------------
  logic [3:0]  wmask;
  logic [31:0] wword;
  logic        we;

  always_comb begin
    wmask = 4'b1111;
    wword = writeData;
    case (size)
      2'b00: begin
        wmask = 4'b0001 << lane;
        wword = {4{writeData[7:0]}};
      end
      2'b01: begin
        wmask = 4'b0011 << {lane[1], 1'b0};
        wword = {2{writeData[15:0]}};
      end
      default: ;
    endcase
  end

  // resetN gating keeps a store from landing while reset holds the FSM.
  assign we = accept && resetN && memWrite && !fault_c;

  always_ff @(posedge clock) begin
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (wmask[b]) mem[idx][b*8 +: 8] <= wword[b*8 +: 8];
    end
  end

  // ---------------- FSM ----------------
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE, RESP: begin
        if (accept) begin
          state_nx = (READ_LATENCY == 1) ? RESP : BUSY;
          cnt_nx   = 3'd0;
        end else begin
          state_nx = IDLE;
        end
      end
      BUSY: begin
        if (cnt == LAST) begin
          state_nx = RESP;
          cnt_nx   = 3'd0;
        end else begin
          cnt_nx = cnt + 3'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Result is captured at accept and only moved to the outputs when the
  // response is issued, so readData/fault stay stable between responses.
  logic [31:0] pend_data, data_q;
  logic        pend_fault, fault_q;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      pend_data  <= '0;
      pend_fault <= 1'b0;
      data_q     <= '0;
      fault_q    <= 1'b0;
    end else begin
      if (accept) begin
        pend_data  <= result;
        pend_fault <= fault_c;
      end
      if (state_nx == RESP) begin
        if (READ_LATENCY == 1) begin
          data_q  <= result;
          fault_q <= fault_c;
        end else begin
          data_q  <= pend_data;
          fault_q <= pend_fault;
        end
      end
    end
  end

  assign readData = data_q;
  assign fault    = fault_q;
endmodule

// File: tb/tb_sized_data_memory.sv
// tb_sized_data_memory: three instances (latency 3, 1, 4) driven by directed
// vector tables and hand-written back-to-back / reset sequences.
module tb_sized_data_memory;
  logic        clk = 1'b0;
  logic        rst_n     [3];
  logic        req       [3];
  logic        ready     [3];
  logic [31:0] address   [3];
  logic [31:0] writeData [3];
  logic        memRead   [3];
  logic        memWrite  [3];
  logic [1:0]  size      [3];
  logic        signExt   [3];
  logic [31:0] readData  [3];
  logic        respValid [3];
  logic        fault     [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 3 : (g == 1) ? 1 : 4;
    sized_data_memory #(.READ_LATENCY(LAT)) u_dut (
      .clock(clk), .resetN(rst_n[g]), .req(req[g]), .ready(ready[g]),
      .address(address[g]), .writeData(writeData[g]), .memRead(memRead[g]),
      .memWrite(memWrite[g]), .size(size[g]), .signExt(signExt[g]),
      .readData(readData[g]), .respValid(respValid[g]), .fault(fault[g]));
  end

  typedef struct {
    logic        rd, wr;
    logic [1:0]  sz;
    logic        se;
    logic [31:0] addr, wd, exp_data;
    logic        exp_fault;
    string       name;
  } vec_t;

  vec_t tbl [24];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs(int i);
    req[i] = 0; memRead[i] = 0; memWrite[i] = 0;
    size[i] = 2'b10; signExt[i] = 0; address[i] = 32'h7FFF0000; writeData[i] = 0;
  endtask

  task automatic drive(int i, vec_t v);
    req[i] = 1; memRead[i] = v.rd; memWrite[i] = v.wr; size[i] = v.sz;
    signExt[i] = v.se; address[i] = v.addr; writeData[i] = v.wd;
  endtask

  // Full transaction starting on a negedge; ends on a negedge.
  task automatic xact(int i, int lat, vec_t v);
    int k = 0, busy = 0, w = 0;
    logic [31:0] held;
    while (!ready[i] && w < 20) begin @(negedge clk); w++; end
    chk({v.name, " ready"}, 32'(ready[i]), 32'd1);
    drive(i, v);
    @(posedge clk); #1 idle_inputs(i);
    for (int c = 1; c <= 20 && k == 0; c++) begin
      @(negedge clk);
      if (respValid[i]) k = c;
      else if (!ready[i]) busy++;
    end
    chk({v.name, " latency"}, 32'(k), 32'(lat));
    chk({v.name, " ready_low"}, 32'(busy), 32'(lat - 1));
    chk({v.name, " data"}, readData[i], v.exp_data);
    chk({v.name, " fault"}, 32'(fault[i]), 32'(v.exp_fault));
    held = readData[i];
    @(negedge clk);
    chk({v.name, " strobe_one"}, 32'(respValid[i]), 32'd0);
    chk({v.name, " hold"}, readData[i], held);
  endtask

  function automatic vec_t mk(logic rd, logic wr, logic [1:0] sz, logic se,
                              logic [31:0] addr, logic [31:0] wd,
                              logic [31:0] ed, logic ef, string nm);
    vec_t v;
    v.rd = rd; v.wr = wr; v.sz = sz; v.se = se; v.addr = addr; v.wd = wd;
    v.exp_data = ed; v.exp_fault = ef; v.name = nm;
    return v;
  endfunction

  initial begin
    vec_t v;
    logic [31:0] vals [4];
    int resp_seen;

    tbl[0]  = mk(0,1,2'b10,0,32'h7FFF0010,32'hDEADBEEF,32'h0,0,"st_w");
    tbl[1]  = mk(1,0,2'b10,0,32'h7FFF0010,32'h0,32'hDEADBEEF,0,"ld_w");
    tbl[2]  = mk(0,1,2'b00,0,32'h7FFF0013,32'hFFFFFF80,32'h0,0,"st_b");
    tbl[3]  = mk(1,0,2'b00,1,32'h7FFF0013,32'h0,32'hFFFFFF80,0,"ld_b_s");
    tbl[4]  = mk(1,0,2'b00,0,32'h7FFF0013,32'h0,32'h00000080,0,"ld_b_z");
    tbl[5]  = mk(1,0,2'b10,0,32'h7FFF0010,32'h0,32'h80ADBEEF,0,"ld_w2");
    tbl[6]  = mk(1,0,2'b01,0,32'h7FFF0011,32'h0,32'h0,1,"f_half_odd");
    tbl[7]  = mk(1,0,2'b10,0,32'h7FFEFFFC,32'h0,32'h0,1,"f_below");
    tbl[8]  = mk(1,0,2'b11,0,32'h7FFF0010,32'h0,32'h0,1,"f_size3");
    tbl[9]  = mk(1,1,2'b10,0,32'h7FFF0010,32'h12345678,32'h0,1,"f_rdwr");
    tbl[10] = mk(0,1,2'b10,0,32'h7FFF0012,32'hFFFFFFFF,32'h0,1,"f_st_mis");
    tbl[11] = mk(1,0,2'b10,0,32'h7FFF0010,32'h0,32'h80ADBEEF,0,"unchanged");
    tbl[12] = mk(0,1,2'b01,0,32'h7FFF0012,32'h0000A5C3,32'h0,0,"st_h");
    tbl[13] = mk(1,0,2'b01,1,32'h7FFF0012,32'h0,32'hFFFFA5C3,0,"ld_h_hi_s");
    tbl[14] = mk(1,0,2'b01,0,32'h7FFF0010,32'h0,32'h0000BEEF,0,"ld_h_lo_z");
    tbl[15] = mk(1,0,2'b01,1,32'h7FFF0010,32'h0,32'hFFFFBEEF,0,"ld_h_lo_s");
    tbl[16] = mk(1,0,2'b00,1,32'h7FFF0011,32'h0,32'hFFFFFFBE,0,"ld_b1_s");
    tbl[17] = mk(1,0,2'b00,0,32'h7FFF0010,32'h0,32'h000000EF,0,"ld_b0_z");
    tbl[18] = mk(0,0,2'b10,0,32'h7FFF0010,32'h0,32'h0,0,"noop");
    tbl[19] = mk(0,1,2'b10,0,32'h7FFFFFFC,32'h11223344,32'h0,0,"st_top");
    tbl[20] = mk(1,0,2'b10,0,32'h7FFFFFFC,32'h0,32'h11223344,0,"ld_top");
    tbl[21] = mk(1,0,2'b10,0,32'h80000000,32'h0,32'h0,1,"f_above");
    tbl[22] = mk(1,0,2'b10,0,32'h7FFF0000,32'h0,32'h0,0,"ld_zero");
    tbl[23] = mk(1,0,2'b00,1,32'h7FFFFFFF,32'h0,32'h00000011,0,"ld_b_top");

    for (int i = 0; i < 3; i++) begin rst_n[i] = 0; idle_inputs(i); end
    // Instance 2 holds a store request during reset; it must not be accepted.
    drive(2, mk(0,1,2'b10,0,32'h7FFF0028,32'h99999999,32'h0,0,"rst_st"));
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst%0d ready", i), 32'(ready[i]), 32'd1);
      chk($sformatf("rst%0d resp", i), 32'(respValid[i]), 32'd0);
      chk($sformatf("rst%0d fault", i), 32'(fault[i]), 32'd0);
      chk($sformatf("rst%0d data", i), readData[i], 32'd0);
    end
    repeat (3) @(negedge clk);
    idle_inputs(2);
    for (int i = 0; i < 3; i++) rst_n[i] = 1;

    // Latency-3 table.
    for (int t = 0; t < 24; t++) xact(0, 3, tbl[t]);

    // Latency 1, req held high, alternating store/load to the top word.
    vals[0] = 32'hA1B2C3D4; vals[1] = 32'h0F0F0F0F;
    vals[2] = 32'h5A5A1234; vals[3] = 32'hFEDCBA98;
    @(negedge clk);
    drive(1, mk(0,1,2'b10,0,32'h7FFFFFFC,vals[0],0,0,"b2b"));
    for (int p = 0; p < 8; p++) begin
      @(negedge clk);
      chk($sformatf("b2b%0d resp", p), 32'(respValid[1]), 32'd1);
      chk($sformatf("b2b%0d ready", p), 32'(ready[1]), 32'd1);
      chk($sformatf("b2b%0d data", p), readData[1], (p % 2) ? vals[p/2] : 32'd0);
      chk($sformatf("b2b%0d fault", p), 32'(fault[1]), 32'd0);
      if (p == 7) idle_inputs(1);
      else if ((p + 1) % 2 == 0)
        drive(1, mk(0,1,2'b10,0,32'h7FFFFFFC,vals[(p+1)/2],0,0,"b2b"));
      else
        drive(1, mk(1,0,2'b10,0,32'h7FFFFFFC,0,0,0,"b2b"));
    end
    @(negedge clk);
    chk("b2b end resp", 32'(respValid[1]), 32'd0);

    // Latency 4: reset mid-BUSY after a committed store.
    xact(2, 4, mk(0,1,2'b10,0,32'h7FFF0020,32'hCAFEF00D,32'h0,0,"r_st"));
    xact(2, 4, mk(1,0,2'b10,0,32'h7FFF0020,32'h0,32'hCAFEF00D,0,"r_ld"));
    drive(2, mk(0,1,2'b10,0,32'h7FFF0024,32'h55AA55AA,0,0,"r_st2"));
    @(posedge clk); #1 idle_inputs(2);
    @(negedge clk);
    chk("r busy ready", 32'(ready[2]), 32'd0);
    @(negedge clk);
    rst_n[2] = 0;
    #1;
    chk("r async ready", 32'(ready[2]), 32'd1);
    chk("r async resp", 32'(respValid[2]), 32'd0);
    chk("r async fault", 32'(fault[2]), 32'd0);
    chk("r async data", readData[2], 32'd0);
    resp_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 1) rst_n[2] = 1;
      if (respValid[2]) resp_seen++;
    end
    chk("r dropped resp", 32'(resp_seen), 32'd0);
    xact(2, 4, mk(1,0,2'b10,0,32'h7FFF0024,32'h0,32'h55AA55AA,0,"r_persist"));
    xact(2, 4, mk(1,0,2'b10,0,32'h7FFF0028,32'h0,32'h0,0,"r_no_accept"));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
